// File: rtl/onewire_write_byte.sv
// 1-Wire master transmitter: eight LSB-first write slots or a reset pulse
// with presence sampling, driving an open-drain pad through drive_low.
module onewire_write_byte #(
  parameter int CLKS_PER_US    = 27,
  parameter int WR1_LOW_US     = 6,
  parameter int WR0_LOW_US     = 60,
  parameter int SLOT_US        = 70,
  parameter int RST_LOW_US     = 480,
  parameter int PRES_SAMPLE_US = 70,
  parameter int RST_TOTAL_US   = 960
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cmd_reset,
  input  logic [7:0] data_in,
  input  logic       onewire_in,
  output logic       drive_low,
  output logic       busy,
  output logic       done,
  output logic       presence
);

  localparam int SLOT_CYC  = SLOT_US * CLKS_PER_US;
  localparam int WR1_CYC   = WR1_LOW_US * CLKS_PER_US;
  localparam int WR0_CYC   = WR0_LOW_US * CLKS_PER_US;
  localparam int RLOW_CYC  = RST_LOW_US * CLKS_PER_US;
  localparam int RSAMP_CYC = (RST_LOW_US + PRES_SAMPLE_US) * CLKS_PER_US;
  localparam int RTOT_CYC  = RST_TOTAL_US * CLKS_PER_US;
  localparam int CW        = $clog2(RTOT_CYC + 1);

  localparam logic [CW-1:0] C_SLOT_LAST = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] C_WR1       = CW'(WR1_CYC);
  localparam logic [CW-1:0] C_WR0       = CW'(WR0_CYC);
  localparam logic [CW-1:0] C_RLOW      = CW'(RLOW_CYC);
  localparam logic [CW-1:0] C_RSAMP     = CW'(RSAMP_CYC);
  localparam logic [CW-1:0] C_RST_LAST  = CW'(RTOT_CYC - 1);
  localparam logic [CW-1:0] C_ONE       = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_RESET,
    S_FINISH
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_drive;
  logic          r_busy;
  logic          r_done;
  logic          r_pres;
  logic          r_sync1;
  logic          r_sync2;

  logic [CW-1:0] w_cnt_nx;
  logic [CW-1:0] w_low_len;

  assign w_cnt_nx  = r_cnt + C_ONE;
  assign w_low_len = r_shift[0] ? C_WR1 : C_WR0;

  // Bus level is asynchronous; idle bus reads high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= onewire_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_drive <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pres  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shift <= data_in;
            r_bit   <= '0;
            r_cnt   <= '0;
            r_pres  <= 1'b0;
            r_busy  <= 1'b1;
            r_drive <= 1'b1;
            r_state <= cmd_reset ? S_RESET : S_WRITE;
          end
        end
        S_WRITE: begin
          if (r_cnt == C_SLOT_LAST) begin
            r_cnt   <= '0;
            r_shift <= {1'b0, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
              r_state <= S_FINISH;
              r_busy  <= 1'b0;
              r_drive <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              // Next slot opens with its low edge immediately.
              r_drive <= 1'b1;
            end
          end else begin
            r_cnt   <= w_cnt_nx;
            r_drive <= (w_cnt_nx < w_low_len);
          end
        end
        S_RESET: begin
          if (r_cnt == C_RSAMP)
            r_pres <= ~r_sync2;
          if (r_cnt == C_RST_LAST) begin
            r_cnt   <= '0;
            r_state <= S_FINISH;
            r_busy  <= 1'b0;
            r_drive <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt   <= w_cnt_nx;
            r_drive <= (w_cnt_nx < C_RLOW);
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign drive_low = r_drive;
  assign busy      = r_busy;
  assign done      = r_done;
  assign presence  = r_pres;

endmodule
